// File: rtl/fmul_sig_arbiter.sv
// fmul_sig_arbiter: two-requester round-robin front end for a shared
// significand multiply/normalise/round unit. A granted request's operands
// are registered onto the unit, held for LATENCY cycles, and the unit results
// are then captured into a tagged response with valid/ready backpressure.
// Optional grant counters are compiled in with FMUL_ARB_STATS_EN.
module fmul_sig_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [23:0] req0_mx,
  input  logic [23:0] req0_my,
  input  logic [23:0] req1_mx,
  input  logic [23:0] req1_my,
  input  logic [1:0]  req0_rmode,
  input  logic [1:0]  req1_rmode,
  input  logic        req0_sz,
  input  logic        req1_sz,
  output logic [23:0] sig_mx,
  output logic [23:0] sig_my,
  output logic [1:0]  sig_rmode,
  output logic        sig_sz,
  input  logic [22:0] sig_mz,
  input  logic        sig_ovf,
  input  logic [4:0]  sig_shl,
  input  logic        sig_ovr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [22:0] rsp_mz,
  output logic        rsp_ovf,
  output logic [4:0]  rsp_shl,
  output logic        rsp_ovr
`ifdef FMUL_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_gnt0,
  output logic [15:0] stat_gnt1
`endif
);

  // Counter wide enough for LATENCY-1, never narrower than one bit.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [23:0] mx;
    logic [23:0] my;
    logic [1:0]  rmode;
    logic        sz;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [22:0] mz;
    logic        ovf;
    logic [4:0]  shl;
    logic        ovr;
  } rsp_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  op_t           op_q, op_d;
  rsp_t          rsp_q, rsp_d;
  logic          rsp_valid_q, rsp_valid_d;

  logic gnt;
  logic req_hs;
  op_t  op0, op1;

  assign op0 = '{mx: req0_mx, my: req0_my, rmode: req0_rmode, sz: req0_sz};
  assign op1 = '{mx: req1_mx, my: req1_my, rmode: req1_rmode, sz: req1_sz};

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    gnt       = req_valid[1] & (~req_valid[0] | ~last_q);
    req_ready = '0;
    if (rst_n && state_q == IDLE && |req_valid) req_ready[gnt] = 1'b1;
  end

  assign req_hs = |(req_valid & req_ready);

  // Next-state: accept in IDLE, count down in BUSY, hold response until taken in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    op_d        = op_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          op_d    = gnt ? op1 : op0;
          id_d    = gnt;
          last_d  = gnt;
          cnt_d   = CW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_d       = '{id: id_q, mz: sig_mz, ovf: sig_ovf, shl: sig_shl, ovr: sig_ovr};
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign sig_mx    = op_q.mx;
  assign sig_my    = op_q.my;
  assign sig_rmode = op_q.rmode;
  assign sig_sz    = op_q.sz;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_mz    = rsp_q.mz;
  assign rsp_ovf   = rsp_q.ovf;
  assign rsp_shl   = rsp_q.shl;
  assign rsp_ovr   = rsp_q.ovr;

`ifdef FMUL_ARB_STATS_EN
  logic [15:0] gnt0_q, gnt0_d;
  logic [15:0] gnt1_q, gnt1_d;

  // Saturating per-requester handshake counters; clear beats increment.
  always_comb begin
    gnt0_d = gnt0_q;
    gnt1_d = gnt1_q;
    if (stat_clr) begin
      gnt0_d = '0;
      gnt1_d = '0;
    end else begin
      if (req_valid[0] && req_ready[0] && gnt0_q != 16'hFFFF) gnt0_d = gnt0_q + 16'd1;
      if (req_valid[1] && req_ready[1] && gnt1_q != 16'hFFFF) gnt1_d = gnt1_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q <= '0;
      gnt1_q <= '0;
    end else begin
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
    end
  end

  assign stat_gnt0 = gnt0_q;
  assign stat_gnt1 = gnt1_q;
`endif

endmodule

// File: tb/tb_fmul_sig_arbiter.sv
// Directed bench for fmul_sig_arbiter: instance a at LATENCY=1, instance b
// at LATENCY=4, sharing stimulus. Build with FMUL_ARB_STATS_EN to also
// exercise the grant counters.
module tb_fmul_sig_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [23:0] req0_mx, req0_my, req1_mx, req1_my;
  logic [1:0]  req0_rmode, req1_rmode;
  logic        req0_sz, req1_sz;
  logic [22:0] sig_mz;
  logic        sig_ovf, sig_ovr;
  logic [4:0]  sig_shl;
  logic        rsp_ready;

  logic [1:0]  a_req_ready, b_req_ready;
  logic [23:0] a_sig_mx, a_sig_my, b_sig_mx, b_sig_my;
  logic [1:0]  a_sig_rmode, b_sig_rmode;
  logic        a_sig_sz, b_sig_sz;
  logic        a_rsp_valid, a_rsp_id, a_rsp_ovf, a_rsp_ovr;
  logic        b_rsp_valid, b_rsp_id, b_rsp_ovf, b_rsp_ovr;
  logic [22:0] a_rsp_mz, b_rsp_mz;
  logic [4:0]  a_rsp_shl, b_rsp_shl;
`ifdef FMUL_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] a_stat_gnt0, a_stat_gnt1, b_stat_gnt0, b_stat_gnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fmul_sig_arbiter #(.LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req0_mx(req0_mx), .req0_my(req0_my), .req1_mx(req1_mx), .req1_my(req1_my),
    .req0_rmode(req0_rmode), .req1_rmode(req1_rmode), .req0_sz(req0_sz), .req1_sz(req1_sz),
    .sig_mx(a_sig_mx), .sig_my(a_sig_my), .sig_rmode(a_sig_rmode), .sig_sz(a_sig_sz),
    .sig_mz(sig_mz), .sig_ovf(sig_ovf), .sig_shl(sig_shl), .sig_ovr(sig_ovr),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id), .rsp_mz(a_rsp_mz),
    .rsp_ovf(a_rsp_ovf), .rsp_shl(a_rsp_shl), .rsp_ovr(a_rsp_ovr)
`ifdef FMUL_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_gnt0(a_stat_gnt0), .stat_gnt1(a_stat_gnt1)
`endif
  );

  fmul_sig_arbiter #(.LATENCY(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req0_mx(req0_mx), .req0_my(req0_my), .req1_mx(req1_mx), .req1_my(req1_my),
    .req0_rmode(req0_rmode), .req1_rmode(req1_rmode), .req0_sz(req0_sz), .req1_sz(req1_sz),
    .sig_mx(b_sig_mx), .sig_my(b_sig_my), .sig_rmode(b_sig_rmode), .sig_sz(b_sig_sz),
    .sig_mz(sig_mz), .sig_ovf(sig_ovf), .sig_shl(sig_shl), .sig_ovr(sig_ovr),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_mz(b_rsp_mz),
    .rsp_ovf(b_rsp_ovf), .rsp_shl(b_rsp_shl), .rsp_ovr(b_rsp_ovr)
`ifdef FMUL_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_gnt0(b_stat_gnt0), .stat_gnt1(b_stat_gnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

`ifdef FMUL_ARB_STATS_EN
  // One full transaction on instance a from the requester(s) in v.
  task automatic issue(input logic [1:0] v);
    int n;
    req_valid = v;
    #1;
    n = 0;
    while (a_req_ready != v && n < 10) begin
      tick();
      n++;
    end
    chk("issue_gnt", a_req_ready, v);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    req0_mx = '0; req0_my = '0; req1_mx = '0; req1_my = '0;
    req0_rmode = '0; req1_rmode = '0; req0_sz = 1'b0; req1_sz = 1'b0;
    sig_mz = '0; sig_ovf = 1'b0; sig_shl = '0; sig_ovr = 1'b0;
`ifdef FMUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #7;
    // Reset state, with both requests asserted during reset.
    chk("rst_req_ready", a_req_ready, 2'b00);
    chk("rst_sig_mx", a_sig_mx, 24'h0);
    chk("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk("rst_rsp_mz", a_rsp_mz, 23'h0);
    chk("rst_rsp_id", a_rsp_id, 1'b0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;

    // 1. single request from requester 0
    tick();
    req_valid = 2'b01; req0_mx = 24'h800000; req0_my = 24'h800000;
    req0_rmode = 2'd0; req0_sz = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("t1_req_ready", a_req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_sig_mx", a_sig_mx, 24'h800000);
    chk("t1_sig_my", a_sig_my, 24'h800000);
    chk("t1_busy_ready", a_req_ready, 2'b00);
    chk("t1_no_rsp_yet", a_rsp_valid, 1'b0);
    tick();
    chk("t1_rsp_valid", a_rsp_valid, 1'b1);
    chk("t1_rsp_id", a_rsp_id, 1'b0);
    chk("t1_rsp_mz", a_rsp_mz, 23'h0);
    tick();
    chk("t1_rsp_done", a_rsp_valid, 1'b0);

    // 2. round robin, both valid continuously; grants exactly 3 cycles apart
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant", a_req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick();
      chk("t2_busy_ready", a_req_ready, 2'b00);
      tick();
      chk("t2_rsp_valid", a_rsp_valid, 1'b1);
      chk("t2_rsp_id", a_rsp_id, k % 2);
      tick();
    end
    req_valid = 2'b00;

    // 3. backpressure on a requester-1 response
    do_reset();
    req_valid = 2'b10; req1_mx = 24'hC00000; req1_my = 24'hC00000;
    req1_rmode = 2'd2; req1_sz = 1'b1;
    sig_mz = 23'h100000; sig_ovf = 1'b1; sig_shl = 5'd0; sig_ovr = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("t3_req_ready", a_req_ready, 2'b10);
    tick();
    req_valid = 2'b11;
    chk("t3_sig_mx", a_sig_mx, 24'hC00000);
    chk("t3_sig_rmode", a_sig_rmode, 2'd2);
    chk("t3_sig_sz", a_sig_sz, 1'b1);
    tick();
    sig_mz = 23'h0; sig_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", a_rsp_valid, 1'b1);
      chk("t3_stall_mz", a_rsp_mz, 23'h100000);
      chk("t3_stall_ovf", a_rsp_ovf, 1'b1);
      chk("t3_stall_id", a_rsp_id, 1'b1);
      chk("t3_stall_ready", a_req_ready, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t3_rsp_done", a_rsp_valid, 1'b0);
    chk("t3_mz_retained", a_rsp_mz, 23'h100000);
    chk("t3_next_grant", a_req_ready, 2'b01);
    req_valid = 2'b00;

    // 4. LATENCY=4 samples the unit exactly 4 edges after accept
    do_reset();
    req_valid = 2'b01; req0_mx = 24'h123456; req0_my = 24'h654321;
    rsp_ready = 1'b0;
    #1;
    chk("t4_req_ready", b_req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    sig_mz = 23'h100; sig_shl = 5'd1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t4_sig_stable", b_sig_mx, 24'h123456);
      chk("t4_no_rsp", b_rsp_valid, 1'b0);
      sig_mz = 23'h100 + 23'(k);
      sig_shl = 5'(k + 1);
    end
    tick();
    chk("t4_rsp_valid", b_rsp_valid, 1'b1);
    chk("t4_rsp_mz", b_rsp_mz, 23'h103);
    chk("t4_rsp_shl", b_rsp_shl, 5'd4);
    chk("t4_sig_my", b_sig_my, 24'h654321);

    // 5. async reset while busy
    do_reset();
    req_valid = 2'b01; req0_mx = 24'hABCDEF; rsp_ready = 1'b1;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_sig_before", b_sig_mx, 24'hABCDEF);
    rst_n = 1'b0;
    #1;
    chk("t5_async_sig", b_sig_mx, 24'h0);
    chk("t5_async_rsp", b_rsp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      chk("t5_no_rsp", b_rsp_valid, 1'b0);
    end
    req_valid = 2'b11;
    #1;
    chk("t5_first_grant_b", b_req_ready, 2'b01);
    chk("t5_first_grant_a", a_req_ready, 2'b01);

`ifdef FMUL_ARB_STATS_EN
    // 6. grant counters and clear priority
    do_reset();
    rsp_ready = 1'b1;
    chk("t6_rst_gnt0", a_stat_gnt0, 16'd0);
    issue(2'b01);
    issue(2'b01);
    issue(2'b01);
    issue(2'b10);
    issue(2'b10);
    chk("t6_gnt0", a_stat_gnt0, 16'd3);
    chk("t6_gnt1", a_stat_gnt1, 16'd2);
    req_valid = 2'b01;
    stat_clr = 1'b1;
    #1;
    chk("t6_clr_grant", a_req_ready, 2'b01);
    tick();
    stat_clr = 1'b0;
    req_valid = 2'b00;
    chk("t6_clr_gnt0", a_stat_gnt0, 16'd0);
    chk("t6_clr_gnt1", a_stat_gnt1, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
